// File: rtl/lfsr_sseg_display.sv
// Parametrised Fibonacci LFSR pattern generator with a multiplexed,
// common-anode seven-segment driver, hold control, step-count display
// mode and a raw LFSR observation port.
module lfsr_sseg_display #(
    parameter int WIDTH         = 16,
    parameter     TAPS          = 16'hB400,
    parameter     SEED          = 16'hACE1,
    parameter int NUM_DIGITS    = 4,
    parameter int PRESCALE_BITS = 24,
    parameter int SCAN_BITS     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            clkscale,
    input  logic                  dispToggle,
    input  logic                  hold,
    output logic [7:0]            sseg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [WIDTH-1:0]      lfsr_out
);

    localparam int                       DW       = 4 * NUM_DIGITS;
    localparam logic [WIDTH-1:0]         TAP_MASK = WIDTH'(TAPS);
    localparam logic [WIDTH-1:0]         SEED_RAW = WIDTH'(SEED);
    // An all-zero seed would lock the register up, so it is replaced by 1.
    localparam logic [WIDTH-1:0]         SEED_EFF = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;
    localparam logic [PRESCALE_BITS-1:0] PRE_ONES = '1;

    logic [PRESCALE_BITS-1:0] prescaler;
    logic [PRESCALE_BITS-1:0] tick_mask;
    logic                     step_tick;
    logic                     step_en;
    logic [WIDTH-1:0]         lfsr;
    logic [WIDTH-1:0]         lfsr_next;
    logic [DW-1:0]            step_cnt;
    logic [SCAN_BITS-1:0]     scan_cnt;
    logic                     scan_tick;
    logic [2:0]               digit;
    logic [DW-1:0]            disp_val;
    logic [3:0]               nibble;
    logic [6:0]               seg_code;

    assign lfsr_out = lfsr;

    // Step tick: the low (PRESCALE_BITS - clkscale) prescaler bits are all ones.
    always_comb begin
        tick_mask = PRE_ONES >> clkscale;
        step_tick = &(prescaler | ~tick_mask);
        step_en   = step_tick & ~hold;
    end

    // Free-running step prescaler; keeps counting while held.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRESCALE_BITS'(1);
        end
    end

    // Next LFSR state: shift in tap parity, or reload the seed on lock-up.
    always_comb begin
        if (lfsr == '0) begin
            lfsr_next = SEED_EFF;
        end else begin
            lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
        end
    end

    // LFSR and step counter advance together on every qualified step.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr     <= SEED_EFF;
            step_cnt <= '0;
        end else if (step_en) begin
            lfsr     <= lfsr_next;
            step_cnt <= step_cnt + DW'(1);
        end
    end

    assign scan_tick = &scan_cnt;

    // Digit refresh: the scan counter wraps and advances the digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            if (scan_tick) begin
                digit <= (digit == 3'(NUM_DIGITS - 1)) ? '0 : digit + 3'd1;
            end
        end
    end

    // Select the displayed value and the nibble for the current digit, then decode.
    always_comb begin
        disp_val = dispToggle ? step_cnt : DW'(lfsr);
        nibble   = 4'(disp_val >> {digit, 2'b00});
        case (nibble)
            4'h0:    seg_code = 7'b1000000;
            4'h1:    seg_code = 7'b1111001;
            4'h2:    seg_code = 7'b0100100;
            4'h3:    seg_code = 7'b0110000;
            4'h4:    seg_code = 7'b0011001;
            4'h5:    seg_code = 7'b0010010;
            4'h6:    seg_code = 7'b0000010;
            4'h7:    seg_code = 7'b1111000;
            4'h8:    seg_code = 7'b0000000;
            4'h9:    seg_code = 7'b0010000;
            4'hA:    seg_code = 7'b0001000;
            4'hB:    seg_code = 7'b0000011;
            4'hC:    seg_code = 7'b1000110;
            4'hD:    seg_code = 7'b0100001;
            4'hE:    seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    end

    // Registered display outputs; dp marks digit 0 in step-count mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            sseg <= 8'hFF;
            an   <= '1;
        end else begin
            sseg <= {~(dispToggle && (digit == 3'd0)), seg_code};
            an   <= ~(NUM_DIGITS'(1) << digit);
        end
    end

endmodule

// File: tb/tb_lfsr_sseg_display.sv
// Scoreboard bench for lfsr_sseg_display (PRESCALE_BITS=8, SCAN_BITS=2).
module tb_lfsr_sseg_display;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  clkscale;
    logic        dispToggle;
    logic        hold;
    logic [7:0]  sseg;
    logic [3:0]  an;
    logic [15:0] lfsr_out;

    lfsr_sseg_display #(
        .PRESCALE_BITS (8),
        .SCAN_BITS     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clkscale   (clkscale),
        .dispToggle (dispToggle),
        .hold       (hold),
        .sseg       (sseg),
        .an         (an),
        .lfsr_out   (lfsr_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  sseg;
        logic [3:0]  an;
        logic [15:0] lfsr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    logic [15:0] m_lfsr  = SEED;
    logic [15:0] m_steps = '0;
    int unsigned m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Apply inputs for the next edge and push the model's view of that edge.
    task automatic cycle(input logic r, input logic [2:0] cs, input logic dt, input logic h);
        exp_t        e;
        int unsigned period;
        int unsigned dig;
        logic [15:0] val;
        @(negedge clk);
        reset = r; clkscale = cs; dispToggle = dt; hold = h;
        if (r) begin
            m_lfsr = SEED; m_steps = '0; m_cnt = 0;
            e.sseg = 8'hFF; e.an = 4'hF;
        end else begin
            period = 1 << (8 - cs);
            dig    = (m_cnt / 4) % 4;
            val    = dt ? m_steps : m_lfsr;
            e.sseg = {(dt && dig == 0) ? 1'b0 : 1'b1, seg_tab[(val >> (4 * dig)) & 16'hF]};
            e.an   = 4'hF ^ 4'(1 << dig);
            if ((m_cnt % period) == period - 1 && !h) begin
                if (m_lfsr == 0) m_lfsr = SEED;
                else m_lfsr = {m_lfsr[14:0], 1'($countones(m_lfsr & TAPS) % 2)};
                m_steps = m_steps + 16'd1;
            end
            m_cnt++;
        end
        e.lfsr = m_lfsr;
        q.push_back(e);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after each edge, compare DUT outputs against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_sseg", 32'(sseg), 32'(e.sseg));
                chk("sb_an", 32'(an), 32'(e.an));
                chk("sb_lfsr", 32'(lfsr_out), 32'(e.lfsr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_cnt;
        int k;
        reset = 1'b1; clkscale = 3'd0; dispToggle = 1'b0; hold = 1'b0;

        repeat (3) cycle(1'b1, 3'd0, 1'b0, 1'b0);
        sample();
        chk("rst_sseg", 32'(sseg), 32'h0FF);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_lfsr", 32'(lfsr_out), 32'hACE1);

        cycle(1'b0, 3'd7, 1'b0, 1'b0);
        sample();
        chk("first_an", 32'(an), 32'hE);
        chk("first_sseg", 32'(sseg), 32'h0F9);
        cycle(1'b0, 3'd7, 1'b0, 1'b0);
        sample();
        chk("step1", 32'(lfsr_out), 32'h59C3);
        cycle(1'b0, 3'd7, 1'b0, 1'b0);
        sample();
        chk("step1_hold_gap", 32'(lfsr_out), 32'h59C3);
        cycle(1'b0, 3'd7, 1'b0, 1'b0);
        sample();
        chk("step2", 32'(lfsr_out), 32'hB387);

        repeat (20) cycle(1'b0, 3'd7, 1'b0, 1'b1);
        sample();
        chk("hold_lfsr", 32'(lfsr_out), 32'hB387);
        repeat (2) cycle(1'b0, 3'd7, 1'b0, 1'b0);
        sample();
        chk("resume_step3", 32'(lfsr_out), 32'h670F);

        e_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 3'd7, 1'b1, 1'b1);
            sample();
            if (an == 4'hE) begin
                e_cnt++;
                chk("cnt_digit0_dp", 32'(sseg), 32'h030);
            end else begin
                chk("cnt_digit_hi", 32'(sseg), 32'h0C0);
            end
        end
        chk("digit0_visits", 32'(e_cnt), 32'd4);
        repeat (4) cycle(1'b0, 3'd7, 1'b0, 1'b1);
        sample();
        chk("toggle_keeps_lfsr", 32'(lfsr_out), 32'h670F);

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0);
        end

        repeat (5) cycle(1'b0, 3'd7, 1'b1, 1'b0);
        cycle(1'b1, 3'd7, 1'b0, 1'b1);
        sample();
        chk("midrun_rst_sseg", 32'(sseg), 32'h0FF);
        chk("midrun_rst_an", 32'(an), 32'hF);
        chk("midrun_rst_lfsr", 32'(lfsr_out), 32'hACE1);
        cycle(1'b0, 3'd7, 1'b0, 1'b0);

        k = 0;
        while (q.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
